// File: rtl/op_tx_scheduler.sv
// op_tx_scheduler
//   Arbitrates 40-bit operation packets from three requesters (power-on
//   response, audio sample request, keyboard/mouse data) into a single packet
//   serializer. Each source has sticky pending state. Fixed priority is
//   power-on > audio > keyboard. A streak counter lets a waiting keyboard word
//   overtake audio after AUDIO_STREAK_MAX consecutive audio grants. A
//   start/done handshake drives the serializer, and an inter-packet gap is
//   inserted after every packet.
//
// Ports
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   power_on_req  in   one-cycle request for the power-on packet
//   audio_req     in   one-cycle request for an audio sample request packet
//   kbd_valid     in   keyboard word offered (source holds it until accepted)
//   kbd_is_mouse  in   qualifies kbd_data as mouse data
//   kbd_data      in   16-bit keyboard/mouse payload
//   kbd_ready     out  keyboard holding register empty
//   tx_data       out  packet to the serializer, stable from tx_start to tx_done
//   tx_start      out  one-cycle pulse, tx_data valid
//   tx_done       in   one-cycle pulse from the serializer, packet sent
//   audio_drop    out  one-cycle pulse, an audio request was merged
//   tx_timeout    out  one-cycle pulse, tx_done never arrived
//   busy          out  high whenever the scheduler is not idle
module op_tx_scheduler #(
  parameter int GAP_CYCLES       = 4,
  parameter int AUDIO_STREAK_MAX = 3,
  parameter int TX_TIMEOUT       = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        power_on_req,
  input  logic        audio_req,
  input  logic        kbd_valid,
  input  logic        kbd_is_mouse,
  input  logic [15:0] kbd_data,
  output logic        kbd_ready,
  output logic [39:0] tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        audio_drop,
  output logic        tx_timeout,
  output logic        busy
);

  localparam int TMR_W = $clog2(TX_TIMEOUT + 1) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1) + 1;

  localparam logic [39:0]      PKT_PON    = 40'hC671000000;
  localparam logic [39:0]      PKT_AUD    = 40'h0700000000;
  localparam logic [3:0]       STREAK_MAX = 4'(AUDIO_STREAK_MAX);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TX_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic             pon_p_q, pon_p_d;
  logic             aud_p_q, aud_p_d;
  logic             kbd_full_q, kbd_full_d;
  logic [15:0]      kbd_data_q;
  logic             kbd_mouse_q;
  logic [3:0]       streak_q, streak_d;
  logic [39:0]      tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             audio_drop_q, audio_drop_d;
  logic             tx_timeout_q, tx_timeout_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             idle;
  logic             kbd_boost;
  logic             kbd_cap;
  logic             grant_pon, grant_aud, grant_kbd;
  logic [39:0]      kbd_pkt;

  assign idle      = (state_q == S_IDLE);
  // A waiting keyboard word that has watched AUDIO_STREAK_MAX audio grants
  // now outranks audio (but never power-on).
  assign kbd_boost = kbd_full_q && (streak_q == STREAK_MAX);
  assign kbd_cap   = kbd_valid && !kbd_full_q;

  assign grant_pon = idle && pon_p_q;
  assign grant_aud = idle && !pon_p_q && aud_p_q && !kbd_boost;
  assign grant_kbd = idle && !pon_p_q && kbd_full_q && (!aud_p_q || kbd_boost);

  assign kbd_pkt   = {8'hC6, (kbd_mouse_q ? 8'h01 : 8'h10), 8'h00, kbd_data_q};

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    gap_d        = gap_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    tx_timeout_d = 1'b0;

    // A request arriving on its own grant edge re-arms the flag.
    pon_p_d      = power_on_req || (pon_p_q && !grant_pon);
    aud_p_d      = audio_req || (aud_p_q && !grant_aud);
    audio_drop_d = audio_req && aud_p_q && !grant_aud;

    // The grant edge frees the register; capture is only possible once
    // kbd_ready is seen high, i.e. from the following cycle on.
    kbd_full_d   = kbd_full_q;
    if (kbd_cap) begin
      kbd_full_d = 1'b1;
    end else if (grant_kbd) begin
      kbd_full_d = 1'b0;
    end

    streak_d = streak_q;
    if (!kbd_full_q || grant_kbd) begin
      streak_d = '0;
    end else if (grant_aud && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (grant_pon || grant_aud || grant_kbd) begin
          state_d    = S_WAIT;
          timer_d    = '0;
          tx_start_d = 1'b1;
          if (grant_pon) begin
            tx_data_d = PKT_PON;
          end else if (grant_aud) begin
            tx_data_d = PKT_AUD;
          end else begin
            tx_data_d = kbd_pkt;
          end
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // tx_done coinciding with our own tx_start pulse is stale.
        if (tx_done && !tx_start_q) begin
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          gap_d   = '0;
        end else if (timer_q == TMR_LAST) begin
          tx_timeout_d = 1'b1;
          state_d      = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          gap_d        = '0;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pon_p_q      <= 1'b0;
      aud_p_q      <= 1'b0;
      kbd_full_q   <= 1'b0;
      streak_q     <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      audio_drop_q <= 1'b0;
      tx_timeout_q <= 1'b0;
      timer_q      <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      pon_p_q      <= pon_p_d;
      aud_p_q      <= aud_p_d;
      kbd_full_q   <= kbd_full_d;
      streak_q     <= streak_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      audio_drop_q <= audio_drop_d;
      tx_timeout_q <= tx_timeout_d;
      timer_q      <= timer_d;
      gap_q        <= gap_d;
    end
  end

  // Payload holding register; its validity is tracked by kbd_full_q.
  always_ff @(posedge clk) begin
    if (kbd_cap) begin
      kbd_data_q  <= kbd_data;
      kbd_mouse_q <= kbd_is_mouse;
    end
  end

  assign kbd_ready  = !kbd_full_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign audio_drop = audio_drop_q;
  assign tx_timeout = tx_timeout_q;
  assign busy       = !idle;

endmodule

// File: tb/tb_op_tx_scheduler.sv
module tb_op_tx_scheduler;

  localparam int GAP    = 4;
  localparam int STREAK = 3;
  localparam int TO     = 40;

  localparam logic [39:0] P_PON = 40'hC671000000;
  localparam logic [39:0] P_AUD = 40'h0700000000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        power_on_req = 1'b0;
  logic        audio_req = 1'b0;
  logic        kbd_valid = 1'b0;
  logic        kbd_is_mouse = 1'b0;
  logic [15:0] kbd_data = 16'h0000;
  logic        kbd_ready;
  logic [39:0] tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        audio_drop;
  logic        tx_timeout;
  logic        busy;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int drops = 0;
  int touts = 0;
  int to_cyc = -1;
  int busy_cnt = 0;

  logic [39:0] exp_q[$];
  logic [39:0] seen_q[$];
  int          seen_cyc[$];
  logic        seen_rdy[$];

  bit done_en = 1'b1;
  int done_cnt = -1;

  op_tx_scheduler #(
    .GAP_CYCLES      (GAP),
    .AUDIO_STREAK_MAX(STREAK),
    .TX_TIMEOUT      (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .power_on_req(power_on_req),
    .audio_req   (audio_req),
    .kbd_valid   (kbd_valid),
    .kbd_is_mouse(kbd_is_mouse),
    .kbd_data    (kbd_data),
    .kbd_ready   (kbd_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .audio_drop  (audio_drop),
    .tx_timeout  (tx_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Serializer model: answers tx_start with tx_done in the following cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      tx_done  = 1'b0;
      done_cnt = -1;
    end else begin
      tx_done = 1'b0;
      if (done_cnt == 0) begin
        tx_done  = 1'b1;
        done_cnt = -1;
      end else if (done_cnt > 0) begin
        done_cnt = done_cnt - 1;
      end
      if (tx_start && done_en) done_cnt = 0;
    end
  end

  function automatic logic [39:0] kpkt(input logic [15:0] d, input logic m);
    return {8'hC6, (m ? 8'h01 : 8'h10), 8'h00, d};
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (reset_n) begin
      if (tx_start) begin
        seen_q.push_back(tx_data);
        seen_cyc.push_back(cyc);
        seen_rdy.push_back(kbd_ready);
      end
      if (audio_drop) drops++;
      if (tx_timeout) begin
        touts++;
        to_cyc = cyc;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic clear_obs();
    exp_q.delete();
    seen_q.delete();
    seen_cyc.delete();
    seen_rdy.delete();
    drops    = 0;
    touts    = 0;
    to_cyc   = -1;
    busy_cnt = 0;
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (seen_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    repeat (GAP + 12) tick();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (kbd_ready !== 1'b1) begin fails++; $display("FAIL reset_kbd_ready: got %b expected 1", kbd_ready); end
    tests++; if (tx_data !== 40'h0) begin fails++; $display("FAIL reset_tx_data: got %h expected 0", tx_data); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (audio_drop !== 1'b0) begin fails++; $display("FAIL reset_audio_drop: got %b expected 0", audio_drop); end
    tests++; if (tx_timeout !== 1'b0) begin fails++; $display("FAIL reset_tx_timeout: got %b expected 0", tx_timeout); end
    reset_n = 1'b1;
    repeat (3) tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_audio_latency();
    int c0;
    clear_obs();
    audio_req = 1'b1;
    exp_q.push_back(P_AUD);
    c0 = cyc;
    tick();
    audio_req = 1'b0;
    run_until(1, 50);
    tests++; if (seen_q.size() !== 1) begin fails++; $display("FAIL lat_count: got %0d expected 1", seen_q.size()); end
    if (seen_q.size() > 0) begin
      tests++; if (seen_q[0] !== exp_q[0]) begin fails++; $display("FAIL lat_data: got %h expected %h", seen_q[0], exp_q[0]); end
      tests++; if (seen_cyc[0] - c0 !== 2) begin fails++; $display("FAIL lat_cycles: got %0d expected 2", seen_cyc[0] - c0); end
    end
    tests++; if (busy_cnt !== GAP + 2) begin fails++; $display("FAIL lat_busy_cycles: got %0d expected %0d", busy_cnt, GAP + 2); end
  endtask

  task automatic test_priority();
    logic exp_rdy[3];
    exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b0; exp_rdy[2] = 1'b1;
    clear_obs();
    power_on_req = 1'b1; audio_req = 1'b1;
    kbd_valid = 1'b1; kbd_data = 16'h1234; kbd_is_mouse = 1'b0;
    exp_q.push_back(P_PON);
    exp_q.push_back(P_AUD);
    exp_q.push_back(kpkt(16'h1234, 1'b0));
    tick();
    power_on_req = 1'b0; audio_req = 1'b0; kbd_valid = 1'b0;
    run_until(3, 200);
    tests++; if (seen_q.size() !== 3) begin fails++; $display("FAIL prio_count: got %0d expected 3", seen_q.size()); end
    for (int i = 0; i < 3 && i < seen_q.size(); i++) begin
      tests++; if (seen_q[i] !== exp_q[i]) begin fails++; $display("FAIL prio_data[%0d]: got %h expected %h", i, seen_q[i], exp_q[i]); end
      tests++; if (seen_rdy[i] !== exp_rdy[i]) begin fails++; $display("FAIL prio_kbd_ready[%0d]: got %b expected %b", i, seen_rdy[i], exp_rdy[i]); end
    end
  endtask

  task automatic test_streak();
    int nreq;
    nreq = STREAK * (GAP + 3) + 2;
    clear_obs();
    for (int i = 0; i < STREAK; i++) exp_q.push_back(P_AUD);
    exp_q.push_back(kpkt(16'hABCD, 1'b1));
    exp_q.push_back(P_AUD);
    kbd_data = 16'hABCD; kbd_is_mouse = 1'b1;
    for (int i = 0; i < nreq; i++) begin
      audio_req = 1'b1;
      kbd_valid = (i == 0);
      tick();
    end
    audio_req = 1'b0; kbd_valid = 1'b0;
    run_until(STREAK + 2, 300);
    tests++; if (seen_q.size() !== STREAK + 2) begin fails++; $display("FAIL streak_count: got %0d expected %0d", seen_q.size(), STREAK + 2); end
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
      tests++; if (seen_q[i] !== exp_q[i]) begin fails++; $display("FAIL streak_data[%0d]: got %h expected %h", i, seen_q[i], exp_q[i]); end
    end
    tests++; if (drops !== nreq - 1 - STREAK) begin fails++; $display("FAIL streak_drops: got %0d expected %0d", drops, nreq - 1 - STREAK); end
  endtask

  task automatic test_drop_merge();
    clear_obs();
    exp_q.push_back(P_PON);
    exp_q.push_back(P_AUD);
    power_on_req = 1'b1; audio_req = 1'b1;
    tick();
    power_on_req = 1'b0;
    tick();
    audio_req = 1'b0;
    run_until(2, 100);
    tests++; if (drops !== 1) begin fails++; $display("FAIL merge_drops: got %0d expected 1", drops); end
    tests++; if (seen_q.size() !== 2) begin fails++; $display("FAIL merge_count: got %0d expected 2", seen_q.size()); end
    for (int i = 0; i < 2 && i < seen_q.size(); i++) begin
      tests++; if (seen_q[i] !== exp_q[i]) begin fails++; $display("FAIL merge_data[%0d]: got %h expected %h", i, seen_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[3];
    logic        m[3];
    int          idx;
    int          k;
    logic        rdy;
    w[0] = 16'h0001; w[1] = 16'h8002; w[2] = 16'hFFFF;
    m[0] = 1'b0;     m[1] = 1'b1;     m[2] = 1'b0;
    clear_obs();
    idx = 0;
    k = 0;
    while (idx < 3 && k < 200) begin
      kbd_valid = 1'b1; kbd_data = w[idx]; kbd_is_mouse = m[idx];
      rdy = kbd_ready;
      tick();
      if (rdy) begin
        exp_q.push_back(kpkt(w[idx], m[idx]));
        idx++;
      end
      k++;
    end
    kbd_valid = 1'b0;
    run_until(3, 100);
    tests++; if (seen_q.size() !== 3) begin fails++; $display("FAIL b2b_count: got %0d expected 3", seen_q.size()); end
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
      tests++; if (seen_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, seen_q[i], exp_q[i]); end
    end
    for (int i = 0; i + 1 < seen_cyc.size(); i++) begin
      tests++; if (seen_cyc[i+1] - seen_cyc[i] !== GAP + 3) begin fails++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, seen_cyc[i+1] - seen_cyc[i], GAP + 3); end
    end
  endtask

  task automatic test_timeout();
    int k;
    clear_obs();
    done_en = 1'b0;
    exp_q.push_back(P_AUD);
    exp_q.push_back(P_PON);
    audio_req = 1'b1;
    tick();
    audio_req = 1'b0; power_on_req = 1'b1;
    tick();
    power_on_req = 1'b0;
    k = 0;
    while (seen_q.size() < 1 && k < 20) begin tick(); k++; end
    tick();
    done_en = 1'b1;
    run_until(2, TO + GAP + 50);
    tests++; if (touts !== 1) begin fails++; $display("FAIL to_pulses: got %0d expected 1", touts); end
    tests++; if (seen_q.size() !== 2) begin fails++; $display("FAIL to_count: got %0d expected 2", seen_q.size()); end
    for (int i = 0; i < 2 && i < seen_q.size(); i++) begin
      tests++; if (seen_q[i] !== exp_q[i]) begin fails++; $display("FAIL to_data[%0d]: got %h expected %h", i, seen_q[i], exp_q[i]); end
    end
    if (seen_cyc.size() > 0) begin
      tests++; if (to_cyc - seen_cyc[0] !== TO) begin fails++; $display("FAIL to_delay: got %0d expected %0d", to_cyc - seen_cyc[0], TO); end
    end
    if (seen_cyc.size() > 1) begin
      tests++; if (seen_cyc[1] - seen_cyc[0] !== TO + GAP + 1) begin fails++; $display("FAIL to_next_start: got %0d expected %0d", seen_cyc[1] - seen_cyc[0], TO + GAP + 1); end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_obs();
    done_en = 1'b0;
    power_on_req = 1'b1;
    kbd_valid = 1'b1; kbd_data = 16'h5A5A; kbd_is_mouse = 1'b1;
    tick();
    power_on_req = 1'b0; kbd_valid = 1'b0;
    k = 0;
    while (seen_q.size() < 1 && k < 20) begin tick(); k++; end
    tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    tests++; if (kbd_ready !== 1'b0) begin fails++; $display("FAIL mid_kbd_ready_before: got %b expected 0", kbd_ready); end
    reset_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b expected 0", busy); end
    tests++; if (kbd_ready !== 1'b1) begin fails++; $display("FAIL mid_kbd_ready: got %b expected 1", kbd_ready); end
    tests++; if (tx_data !== 40'h0) begin fails++; $display("FAIL mid_tx_data: got %h expected 0", tx_data); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL mid_tx_start: got %b expected 0", tx_start); end
    tests++; if (tx_timeout !== 1'b0) begin fails++; $display("FAIL mid_tx_timeout: got %b expected 0", tx_timeout); end
    repeat (2) tick();
    reset_n = 1'b1;
    done_en = 1'b1;
    clear_obs();
    repeat (TO + GAP + 10) tick();
    tests++; if (seen_q.size() !== 0) begin fails++; $display("FAIL mid_spurious_start: got %0d expected 0", seen_q.size()); end
    tests++; if (touts !== 0) begin fails++; $display("FAIL mid_spurious_timeout: got %0d expected 0", touts); end
    exp_q.push_back(P_AUD);
    audio_req = 1'b1;
    tick();
    audio_req = 1'b0;
    run_until(1, 50);
    tests++; if (seen_q.size() !== 1) begin fails++; $display("FAIL mid_after_count: got %0d expected 1", seen_q.size()); end
    if (seen_q.size() > 0) begin
      tests++; if (seen_q[0] !== exp_q[0]) begin fails++; $display("FAIL mid_after_data: got %h expected %h", seen_q[0], exp_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_audio_latency();
    test_priority();
    test_streak();
    test_drop_merge();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/op_tx_scheduler.md
Name: op_tx_scheduler

Overview:
- Sequences and arbitrates outgoing 40-bit operation packets from three requesters into one packet serializer: power-on response, audio sample request, and keyboard/mouse data.
- Holds sticky pending state per source and applies fixed priority with a keyboard anti-starvation guard.
- Drives a start/done handshake to the serializer and inserts a configurable inter-packet gap.
- Sits between the keyboard/audio/power control logic and the monitor-link transmitter.

Parameters:
- GAP_CYCLES, 4: idle cycles after each completed packet before the next grant; 0 means no gap.
- AUDIO_STREAK_MAX, 3: consecutive audio grants allowed while a keyboard packet waits; range 1..15.
- TX_TIMEOUT, 1023: cycles to wait for tx_done before abandoning a packet.

Ports:
- clk in 1: system clock, rising edge.
- reset_n in 1: asynchronous, active-low reset.
- power_on_req in 1: one-cycle request to send the power-on packet.
- audio_req in 1: one-cycle request to send an audio sample request packet.
- kbd_valid in 1: keyboard word offered.
- kbd_is_mouse in 1: qualifies kbd_data as mouse data.
- kbd_data in 16: keyboard/mouse payload.
- kbd_ready out 1: keyboard holding register empty.
- tx_data out 40: packet to the serializer; stable from tx_start until tx_done.
- tx_start out 1: one-cycle pulse, packet valid.
- tx_done in 1: one-cycle pulse from the serializer, packet fully sent.
- audio_drop out 1: one-cycle pulse, audio request coalesced.
- tx_timeout out 1: one-cycle pulse, tx_done not received in time.
- busy out 1: high in any state other than IDLE.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE; all pending flags 0; keyboard register empty.
  - kbd_ready=1; tx_data=0; tx_start=0; audio_drop=0; tx_timeout=0; busy=0; streak=0.
  - Reset mid-packet abandons the packet; no pulse is issued.
- Pending flags pon_p and aud_p:
  - Set on the rising edge that samples the request.
  - Cleared on the edge that grants them.
  - A new request on the grant edge wins, so the flag stays 1.
- audio_drop: audio_req while aud_p=1 and aud_p is not being granted that edge pulses audio_drop the next cycle. The request is merged. power_on_req merges silently.
- Keyboard register:
  - Captures kbd_data and kbd_is_mouse when kbd_valid && kbd_ready.
  - kbd_ready = !kbd_full, a registered state bit.
  - kbd_valid while kbd_ready=0 is ignored; the source holds its data.
  - The register is freed on the keyboard grant edge. kbd_ready rises the next cycle; capture in that same cycle is allowed.
- Packet encodings:
  - Power-on: 40'hC671000000.
  - Audio: 40'h0700000000.
  - Keyboard: {8'hC6, is_mouse?8'h01:8'h10, 8'h00, data[15:0]}.
- Arbitration is evaluated in IDLE only:
  - power-on > audio > keyboard.
  - Exception: if kbd_full and streak==AUDIO_STREAK_MAX, keyboard beats audio but still loses to power-on.
- Streak counter:
  - +1 on each audio grant while kbd_full.
  - Cleared on keyboard grant or whenever kbd_full=0.
  - Saturates at AUDIO_STREAK_MAX.
- State machine:
  - IDLE: any flag pending -> grant. On that edge: register tx_data, pulse tx_start, clear the winner's pending state, go to WAIT.
  - WAIT: tx_done -> GAP, or -> IDLE if GAP_CYCLES=0. Timer reaches TX_TIMEOUT without tx_done -> pulse tx_timeout, go to GAP. The packet is not retried.
  - GAP: count GAP_CYCLES cycles, then -> IDLE. The count is inclusive of entry.
  - tx_done outside WAIT is ignored. tx_done in the tx_start cycle is ignored.
- Latency: request sampled at edge E0 from IDLE with nothing pending -> tx_start high in the cycle after edge E1, i.e. 2 cycles.
- Packet-to-packet spacing, with immediate tx_done: done edge -> GAP_CYCLES cycles -> 1 IDLE cycle -> tx_start.

Test Plan:
- Reset release then audio_req pulse -> tx_start 2 cycles later, tx_data=40'h0700000000, busy=1 until tx_done + GAP_CYCLES.
- power_on_req, audio_req and kbd_valid (data 16'h1234, is_mouse=0) in the same cycle -> packets in order C671000000, 0700000000, C610001234; kbd_ready low until the third grant.
- Keyboard held (data 16'hABCD, is_mouse=1) while audio_req repeats every cycle, AUDIO_STREAK_MAX=3 -> three audio packets, then C60100ABCD, then audio resumes; audio_drop pulses for the merged requests.
- audio_req again while aud_p=1 and not granted -> exactly one audio_drop pulse; one audio packet sent.
- No tx_done after tx_start -> tx_timeout pulses after TX_TIMEOUT cycles; the next pending packet starts after the gap.
- reset_n low during WAIT with a keyboard word held -> all outputs at reset values immediately; kbd_ready=1; no tx_start after release until a new request.
